// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: FSM states and control-bundle bit positions
// of the EX/MEM and MEM/WB control fields.
package mem_access_stage_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        DONE = ST_DONE
    } state_t;

    // MEM control bundle {MemRead, MemWrite, MemtoReg}
    localparam int MEMREAD      = 2;
    localparam int MEMWRITE     = 1;
    localparam int MEM_MEMTOREG = 0;

    // WB control bundle {RegWrite, MemtoReg}
    localparam int REGWRITE     = 1;
    localparam int WB_MEMTOREG  = 0;

    function automatic logic is_mem_op(input logic [2:0] mem_ctl);
        return mem_ctl[MEMREAD] | mem_ctl[MEMWRITE];
    endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads the retiring instruction when the stage is not
// stalled, and inserts a bubble (RegWrite/MemtoReg cleared) while it is.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        done,
    input  logic [1:0]  wb_mem,
    input  logic [4:0]  wn_mem,
    input  logic [31:0] alu_mem,
    input  logic [31:0] rdata,
    output logic [1:0]  wb_wb,
    output logic [4:0]  wn_wb,
    output logic [31:0] rd_wb,
    output logic [31:0] alu_wb
);

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_wb  <= '0;
            wn_wb  <= '0;
            rd_wb  <= '0;
            alu_wb <= '0;
        end else if (stall) begin
            // Bubble: only the control bits are cleared so nothing is written back twice
            wb_wb <= '0;
        end else begin
            wb_wb  <= wb_mem;
            wn_wb  <= wn_mem;
            alu_wb <= alu_mem;
            rd_wb  <= done ? rdata : 32'd0;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs one load/store per instruction on a single-outstanding req/ack bus,
// freezes upstream stages until it completes, and flags bus timeouts stickily.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  WB_MEM,
    input  logic [2:0]  MEM_MEM,
    input  logic [4:0]  WN_MEM,
    input  logic [31:0] RD2_WD_MEM,
    input  logic [31:0] ALUOut_MEM,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic        mem_err,
    output logic [1:0]  WB_WB,
    output logic [4:0]  WN_WB,
    output logic [31:0] RD_WB,
    output logic [31:0] ALUOut_WB
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        req_next, we_next, err_next;
    logic [31:0] addr_next, wdata_next;
    logic        op;
    logic        unused_memtoreg;

    assign op              = is_mem_op(MEM_MEM);
    assign unused_memtoreg = MEM_MEM[MEM_MEMTOREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            mem_req   <= req_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            mem_err   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        req_next   = mem_req;
        we_next    = mem_we;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        err_next   = mem_err;
        stall      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (op) begin
                    stall      = 1'b1;
                    req_next   = 1'b1;
                    // A read wins when both MemRead and MemWrite are set
                    we_next    = MEM_MEM[MEMWRITE] & ~MEM_MEM[MEMREAD];
                    addr_next  = ALUOut_MEM;
                    wdata_next = RD2_WD_MEM;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    rdata_next = mem_we ? 32'd0 : mem_rdata;
                    req_next   = 1'b0;
                    state_next = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    // Abort: the instruction still retires, with zero load data
                    rdata_next = '0;
                    req_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .done    (state_reg == DONE),
        .wb_mem  (WB_MEM),
        .wn_mem  (WN_MEM),
        .alu_mem (ALUOut_MEM),
        .rdata   (rdata_reg),
        .wb_wb   (WB_WB),
        .wn_wb   (WN_WB),
        .rd_wb   (RD_WB),
        .alu_wb  (ALUOut_WB)
    );

endmodule
